// File: rtl/fft_frame_sched.sv
// Frame scheduler arbitrating the shared FFT sample memory between loader, FFT core and unloader.
// Optional macro FFT_SCHED_BITREV_EN: loader writes in bit-reversed address order.
module fft_frame_sched #(
    parameter int unsigned N_FFT  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iIN_VALID,
    output logic              oIN_READY,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic              oWR_EN,
    output logic              oFFT_START,
    input  logic              iFFT_RDY,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic              oRD_EN,
    input  logic              iOUT_READY,
    output logic              oOUT_VALID,
    output logic              oOUT_LAST,
    output logic [1:0]        oMUX_SEL,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic [CNT_W-1:0]  oFRAME_CNT
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_UNLOAD = 3'd4,
        S_DRAIN  = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rdy_q, rdy_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic [1:0]          mux_sel_c;
    logic                in_ready_c;
    logic                fft_start_c;
    logic                rd_en_c;
    logic                busy_c;
    logic                wr_fire_c;
    logic                rdy_rise_c;
    logic [ADDR_W-1:0]   wr_addr_c;

    assign wr_fire_c  = iIN_VALID & in_ready_c;
    assign rdy_rise_c = iFFT_RDY & ~rdy_q;

    // State register
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frames free-run back through IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_LOAD;
            S_LOAD:   if (wr_fire_c && (wr_cnt_q == LAST_ADDR)) state_d = S_START;
            S_START:  state_d = S_RUN;
            S_RUN:    if (rdy_rise_c) state_d = S_UNLOAD;
            S_UNLOAD: if (rd_en_c && (rd_cnt_q == LAST_ADDR)) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; forced quiet while reset is asserted so a stale START never leaks out
    always_comb begin
        mux_sel_c   = 2'd0;
        in_ready_c  = 1'b0;
        fft_start_c = 1'b0;
        rd_en_c     = 1'b0;
        busy_c      = 1'b0;
        if (!iRESET) begin
            busy_c = (state_q != S_IDLE);
            case (state_q)
                S_LOAD: begin
                    mux_sel_c  = 2'd1;
                    in_ready_c = 1'b1;
                end
                S_START: begin
                    mux_sel_c   = 2'd2;
                    fft_start_c = 1'b1;
                end
                S_RUN:    mux_sel_c = 2'd2;
                S_UNLOAD: begin
                    mux_sel_c = 2'd3;
                    rd_en_c   = iOUT_READY;
                end
                // Unloader keeps ownership while the final read word returns
                S_DRAIN:  mux_sel_c = 2'd3;
                default:  mux_sel_c = 2'd0;
            endcase
        end
    end

    // Counters and read-side pipeline; address counters wrap naturally at N_FFT
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rdy_d       = iFFT_RDY;
        out_valid_d = rd_en_c;
        out_last_d  = rd_en_c && (rd_cnt_q == LAST_ADDR);
        frame_cnt_d = frame_cnt_q;
        if (wr_fire_c) wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        if (rd_en_c)   rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        if (out_last_d) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef FFT_SCHED_BITREV_EN
    always_comb begin
        wr_addr_c = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            wr_addr_c[i] = wr_cnt_q[int'(ADDR_W) - 1 - i];
        end
    end
`else
    assign wr_addr_c = wr_cnt_q;
`endif

    assign oIN_READY   = in_ready_c;
    assign oWR_ADDR    = wr_addr_c;
    assign oWR_EN      = wr_fire_c;
    assign oFFT_START  = fft_start_c;
    assign oRD_ADDR    = rd_cnt_q;
    assign oRD_EN      = rd_en_c;
    assign oOUT_VALID  = out_valid_q;
    assign oOUT_LAST   = out_last_q;
    assign oMUX_SEL    = mux_sel_c;
    assign oBUSY       = busy_c;
    assign oFRAME_DONE = out_last_q;
    assign oFRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched (N_FFT=16) against a frame-level reference model.
module tb_fft_frame_sched;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 8;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_START  = 2;
    localparam int P_RUN    = 3;
    localparam int P_UNLOAD = 4;
    localparam int P_DRAIN  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          fft_rdy = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, wr_en, fft_start, rd_en, out_valid, out_last, busy, frame_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    mux_sel;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    // Reference model: frame phase, samples accepted, results requested, completed frames
    int   ph = P_IDLE;
    int   loaded = 0;
    int   unloaded = 0;
    int   fcnt = 0;
    logic m_valid = 1'b0;
    logic m_last = 1'b0;
    logic m_rdy_prev = 1'b0;

    always #5 clk = ~clk;

    fft_frame_sched #(.N_FFT(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .iCLK        (clk),
        .iRESET      (rst),
        .iIN_VALID   (in_valid),
        .oIN_READY   (in_ready),
        .oWR_ADDR    (wr_addr),
        .oWR_EN      (wr_en),
        .oFFT_START  (fft_start),
        .iFFT_RDY    (fft_rdy),
        .oRD_ADDR    (rd_addr),
        .oRD_EN      (rd_en),
        .iOUT_READY  (out_ready),
        .oOUT_VALID  (out_valid),
        .oOUT_LAST   (out_last),
        .oMUX_SEL    (mux_sel),
        .oBUSY       (busy),
        .oFRAME_DONE (frame_done),
        .oFRAME_CNT  (frame_cnt)
    );

    function automatic int bitrev(input int x);
        int r = 0;
        for (int i = 0; i < int'(AW); i++) begin
            if (((x >> i) & 1) != 0) r = r + (1 << (int'(AW) - 1 - i));
        end
        return r;
    endfunction

    function automatic int owner(input int p);
        if (p == P_LOAD) return 1;
        if (p == P_START || p == P_RUN) return 2;
        if (p == P_UNLOAD || p == P_DRAIN) return 3;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, check all outputs, then advance the model at posedge
    task automatic tick(input logic r, input logic v, input logic fr, input logic ordy);
        logic live, e_rd;
        int   e_wa;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        fft_rdy   = fr;
        out_ready = ordy;
        #1;
        live = !r;
        e_rd = live && (ph == P_UNLOAD) && ordy;
`ifdef FFT_SCHED_BITREV_EN
        e_wa = bitrev(loaded);
`else
        e_wa = loaded;
`endif
        chk("mux_sel",    32'(mux_sel),    32'(live ? owner(ph) : 0));
        chk("in_ready",   32'(in_ready),   32'(live && ph == P_LOAD));
        chk("wr_en",      32'(wr_en),      32'(live && ph == P_LOAD && v));
        chk("wr_addr",    32'(wr_addr),    32'(e_wa));
        chk("fft_start",  32'(fft_start),  32'(live && ph == P_START));
        chk("busy",       32'(busy),       32'(live && ph != P_IDLE));
        chk("rd_en",      32'(rd_en),      32'(e_rd));
        chk("rd_addr",    32'(rd_addr),    32'(unloaded));
        chk("out_valid",  32'(out_valid),  32'(m_valid));
        chk("out_last",   32'(out_last),   32'(m_last));
        chk("frame_done", 32'(frame_done), 32'(m_last));
        chk("frame_cnt",  32'(frame_cnt),  32'(fcnt));
        if (fft_start) starts++;
        @(posedge clk);
        if (r) begin
            ph = P_IDLE; loaded = 0; unloaded = 0; fcnt = 0;
            m_valid = 1'b0; m_last = 1'b0; m_rdy_prev = 1'b0;
        end else begin
            m_valid = e_rd;
            m_last  = e_rd && (unloaded == int'(N) - 1);
            if (m_last) fcnt = (fcnt + 1) % (1 << CW);
            case (ph)
                P_IDLE:  ph = P_LOAD;
                P_LOAD:  if (v) begin
                    if (loaded == int'(N) - 1) begin loaded = 0; ph = P_START; end
                    else loaded++;
                end
                P_START: ph = P_RUN;
                P_RUN:   if (fr && !m_rdy_prev) ph = P_UNLOAD;
                P_UNLOAD: if (ordy) begin
                    if (unloaded == int'(N) - 1) begin unloaded = 0; ph = P_DRAIN; end
                    else unloaded++;
                end
                default: ph = P_IDLE;
            endcase
            m_rdy_prev = fr;
        end
    endtask

    // vmode 0: valid always 1, else random. rmode 0: ready 1, 1: toggle 1,0,..., 2: random.
    // FFT ready follows 'pre' until 5 cycles after START, then low for 'delay' cycles, then high.
    task automatic drive_frame(input int vmode, input int rmode, input logic pre,
                               input int delay, input int abort_at);
        int   f0, st0, k;
        logic tog, done, v, fr, ordy;
        f0 = fcnt; st0 = starts; k = -1; tog = 1'b1; done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            v = (vmode == 0) ? 1'b1 : 1'($urandom % 2);
            if (ph == P_START) k = 0;
            else if (k >= 0) k++;
            fr = (k < 5) ? pre : (k >= 5 + delay);
            ordy = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom % 2);
            if (ph == P_UNLOAD) tog = ~tog;
            if (abort_at >= 0 && ph == P_LOAD && loaded == abort_at) begin
                tick(1'b1, v, fr, ordy);
                chk("abort_no_start", 32'(starts - st0), 32'd0);
                return;
            end
            tick(1'b0, v, fr, ordy);
            if (fcnt != f0 && ph == P_IDLE) done = 1'b1;
        end
        chk("frame_complete", 32'(done), 32'd1);
        chk("start_pulses", 32'(starts - st0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom % 2), 1'b0, 1'b1);
        // Full-rate load, FFT ready high before START, toggling unload readiness
        drive_frame(0, 1, 1'b1, 20, -1);
        chk("frame_cnt_after_first", 32'(frame_cnt), 32'd1);
        drive_frame(1, 2, 1'b0, int'($urandom_range(0, 10)), -1);
        // Reset pulse mid-load at count 7 discards the frame
        drive_frame(0, 0, 1'b1, 3, 7);
        drive_frame(1, 2, 1'($urandom % 2), int'($urandom_range(0, 15)), -1);
        chk("frame_cnt_after_abort", 32'(frame_cnt), 32'd1);
        drive_frame(0, 0, 1'b0, 0, -1);
        chk("frame_cnt_final", 32'(frame_cnt), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
